// File: rtl/multicycle_sequencer.sv
// multicycle_sequencer: control FSM for the multicycle MIPS datapath.
// Steps each instruction through FETCH/DECODE/EXEC/MEM/WB, drives the
// per-step enables, counts retired instructions and latches halt.
// Optional feature: define SEQ_WATCHDOG_EN to bound memory waits with a
// watchdog that forces HALT and raises timeout after WD_LIMIT stall cycles.
module multicycle_sequencer #(
  parameter int CNT_W    = 32,
  parameter int WD_LIMIT = 255
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             ihit,
  input  logic             dhit,
  input  logic             memread,
  input  logic             memwr,
  input  logic             regwr,
  input  logic             halt,
  output logic             iREN,
  output logic             dREN,
  output logic             dWEN,
  output logic             irWEN,
  output logic             pcWEN,
  output logic             regWEN,
  output logic             halted,
  output logic             timeout,
  output logic [2:0]       state,
  output logic [CNT_W-1:0] retired
);

  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    EXEC   = 3'd2,
    MEM    = 3'd3,
    WB     = 3'd4,
    HALT   = 3'd5
  } state_t;

  state_t cur, nxt;
  logic   retire;
  logic   trip;     // watchdog expiry this cycle (stall still pending)
  logic   waiting;  // stalled on a memory port this cycle

  assign state   = cur;
  assign waiting = ((cur == FETCH) && !ihit) || ((cur == MEM) && !dhit);

`ifdef SEQ_WATCHDOG_EN
  localparam int WD_W = $clog2(WD_LIMIT + 1);
  logic [WD_W-1:0] wd_cnt;

  assign trip = waiting && (wd_cnt == WD_W'(WD_LIMIT));

  // Watchdog: counts consecutive stall cycles in one state, clears on hit or move
  always_ff @(posedge CLK) begin
    if (RST)                        wd_cnt <= '0;
    else if (!waiting || nxt != cur) wd_cnt <= '0;
    else                            wd_cnt <= wd_cnt + 1'b1;
  end

  // Sticky timeout flag, set on the cycle the watchdog forces HALT
  always_ff @(posedge CLK) begin
    if (RST)       timeout <= 1'b0;
    else if (trip) timeout <= 1'b1;
  end
`else
  assign trip    = 1'b0;
  assign timeout = 1'b0;
`endif

  // Next-state, enables and retire strobe from current state and hit inputs
  always_comb begin
    nxt    = cur;
    retire = 1'b0;
    iREN   = 1'b0;
    dREN   = 1'b0;
    dWEN   = 1'b0;
    irWEN  = 1'b0;
    pcWEN  = 1'b0;
    regWEN = 1'b0;
    case (cur)
      FETCH: begin
        iREN  = 1'b1;
        irWEN = ihit;
        if (ihit)      nxt = DECODE;
        else if (trip) nxt = HALT;
      end
      DECODE: begin
        if (halt) begin
          nxt    = HALT;
          retire = 1'b1;
        end else begin
          nxt = EXEC;
        end
      end
      EXEC: begin
        pcWEN = 1'b1;
        if (memread || memwr) nxt = MEM;
        else if (regwr)       nxt = WB;
        else begin
          nxt    = FETCH;
          retire = 1'b1;
        end
      end
      MEM: begin
        // a store wins when both memread and memwr are set
        dWEN = memwr;
        dREN = memread && !memwr;
        if (dhit) begin
          if (memread && !memwr) nxt = WB;
          else begin
            nxt    = FETCH;
            retire = 1'b1;
          end
        end else if (trip) begin
          nxt = HALT;
        end
      end
      WB: begin
        regWEN = 1'b1;
        nxt    = FETCH;
        retire = 1'b1;
      end
      HALT:    nxt = HALT;
      default: nxt = FETCH;
    endcase
  end

  // State register, retired counter and sticky halt flag
  always_ff @(posedge CLK) begin
    if (RST) begin
      cur     <= FETCH;
      retired <= '0;
      halted  <= 1'b0;
    end else begin
      cur <= nxt;
      if (retire)      retired <= retired + 1'b1;
      if (nxt == HALT) halted  <= 1'b1;
    end
  end

endmodule

// File: tb/tb_multicycle_sequencer.sv
// Randomized bench for multicycle_sequencer. Each instruction is described
// by its decode bits plus ihit/dhit wait counts; the expected state trace,
// enable pulse counts and retire count come from the instruction class.
module tb_multicycle_sequencer;

  logic        CLK = 1'b0;
  logic        RST, ihit, dhit, memread, memwr, regwr, halt;
  logic        iREN, dREN, dWEN, irWEN, pcWEN, regWEN, halted, timeout;
  logic [2:0]  state;
  logic [31:0] retired;

  int          vecs = 0;
  int          errs = 0;
  logic [31:0] exp_ret = 0;

  multicycle_sequencer #(.CNT_W(32), .WD_LIMIT(4)) dut (
    .CLK(CLK), .RST(RST), .ihit(ihit), .dhit(dhit), .memread(memread),
    .memwr(memwr), .regwr(regwr), .halt(halt), .iREN(iREN), .dREN(dREN),
    .dWEN(dWEN), .irWEN(irWEN), .pcWEN(pcWEN), .regWEN(regWEN),
    .halted(halted), .timeout(timeout), .state(state), .retired(retired)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vecs++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    RST = 1'b1; ihit = 0; dhit = 0; memread = 0; memwr = 0; regwr = 0; halt = 0;
    @(negedge CLK);
    @(negedge CLK);
    RST = 1'b0;
    exp_ret = 0;
  endtask

  // Run one instruction from its first FETCH cycle to completion.
  task automatic run_instr(input bit mr, input bit mw, input bit rw, input bit h,
                           input int wi, input int wd);
    int  exp_st[$];
    bit  mem, wb;
    int  n_i, n_ir, n_pc, n_dr, n_dw, n_rw;
    int  e_dr, e_dw;
    mem = mr || mw;
    wb  = mem ? (mr && !mw) : rw;
    repeat (wi + 1) exp_st.push_back(0);
    exp_st.push_back(1);
    if (!h) begin
      exp_st.push_back(2);
      if (mem) repeat (wd + 1) exp_st.push_back(3);
      if (wb) exp_st.push_back(4);
    end
    n_i = 0; n_ir = 0; n_pc = 0; n_dr = 0; n_dw = 0; n_rw = 0;
    for (int c = 0; c < exp_st.size(); c++) begin
      memread = mr; memwr = mw; regwr = rw; halt = h;
      if (c < wi)       ihit = 1'b0;
      else if (c == wi) ihit = 1'b1;
      else              ihit = 1'($urandom);
      if (mem && !h && c >= wi + 3) dhit = (c == wi + 3 + wd);
      else                          dhit = 1'($urandom);
      #1;
      chk("state", 32'(state), 32'(exp_st[c]));
      n_i += int'(iREN); n_ir += int'(irWEN); n_pc += int'(pcWEN);
      n_dr += int'(dREN); n_dw += int'(dWEN); n_rw += int'(regWEN);
      @(negedge CLK);
    end
    e_dr = (!h && mem && mr && !mw) ? wd + 1 : 0;
    e_dw = (!h && mem && mw) ? wd + 1 : 0;
    ihit = 0; dhit = 0;
    #1;
    exp_ret = exp_ret + 1;
    chk("iREN_cnt", 32'(n_i), 32'(wi + 1));
    chk("irWEN_cnt", 32'(n_ir), 32'd1);
    chk("pcWEN_cnt", 32'(n_pc), h ? 32'd0 : 32'd1);
    chk("dREN_cnt", 32'(n_dr), 32'(e_dr));
    chk("dWEN_cnt", 32'(n_dw), 32'(e_dw));
    chk("regWEN_cnt", 32'(n_rw), (!h && wb) ? 32'd1 : 32'd0);
    chk("retired", retired, exp_ret);
    chk("halted", 32'(halted), 32'(h));
    chk("end_state", 32'(state), h ? 32'd5 : 32'd0);
    chk("timeout", 32'(timeout), 32'd0);
  endtask

  // Sit in HALT for 20 cycles with ihit toggling; nothing may move.
  task automatic hold_halt();
    for (int c = 0; c < 20; c++) begin
      ihit = 1'(c); dhit = 1'($urandom);
      #1;
      chk("halt_state", 32'(state), 32'd5);
      chk("halt_en", {26'd0, iREN, dREN, dWEN, irWEN, pcWEN, regWEN}, 32'd0);
      chk("halt_ret", retired, exp_ret);
      @(negedge CLK);
    end
  endtask

  initial begin
    do_reset();
    #1;
    chk("rst_state", 32'(state), 32'd0);
    chk("rst_ret", retired, 32'd0);
    chk("rst_halted", 32'(halted), 32'd0);
    chk("rst_timeout", 32'(timeout), 32'd0);
    chk("rst_en", {26'd0, iREN, dREN, dWEN, irWEN, pcWEN, regWEN}, 32'b100000);

    // R-type, load with waits, load+store together
    run_instr(0, 0, 1, 0, 0, 0);
    run_instr(1, 0, 1, 0, 2, 3);
    run_instr(1, 1, 1, 0, 1, 0);
    // halt after a few instructions
    run_instr(0, 0, 0, 0, 0, 0);
    run_instr(0, 1, 0, 0, 0, 1);
    run_instr(0, 0, 0, 1, 0, 0);
    hold_halt();

    // randomized instruction stream
    do_reset();
    for (int k = 0; k < 300; k++) begin
      bit h;
      h = ($urandom_range(0, 11) == 0);
      run_instr(1'($urandom), 1'($urandom), 1'($urandom), h,
                $urandom_range(0, 3), $urandom_range(0, 3));
      if (h) begin
        hold_halt();
        do_reset();
      end
    end

    // reset mid-MEM with a pending dhit
    do_reset();
    run_instr(0, 0, 1, 0, 0, 0);
    memwr = 1; memread = 1; regwr = 1; ihit = 1;
    @(negedge CLK); ihit = 0;
    @(negedge CLK);
    @(negedge CLK);
    dhit = 1; RST = 1;
    #1;
    chk("mem_before_rst", 32'(state), 32'd3);
    @(negedge CLK);
    RST = 0; dhit = 0;
    #1;
    chk("rst_mem_state", 32'(state), 32'd0);
    chk("rst_mem_ret", retired, 32'd0);
    chk("rst_mem_wr", {30'd0, dWEN, regWEN}, 32'd0);
    @(negedge CLK);
    #1;
    chk("rst_mem_wr2", {30'd0, dWEN, regWEN}, 32'd0);

    // stall in FETCH with ihit held low
    do_reset();
    run_instr(0, 0, 0, 0, 0, 0);
`ifdef SEQ_WATCHDOG_EN
    for (int c = 0; c < 5; c++) begin
      #1;
      chk("wd_fetch", 32'(state), 32'd0);
      @(negedge CLK);
    end
    #1;
    chk("wd_state", 32'(state), 32'd5);
    chk("wd_timeout", 32'(timeout), 32'd1);
    chk("wd_halted", 32'(halted), 32'd1);
    chk("wd_ret", retired, 32'd1);
`else
    for (int c = 0; c < 100; c++) begin
      #1;
      chk("stall_state", 32'(state), 32'd0);
      chk("stall_timeout", 32'(timeout), 32'd0);
      @(negedge CLK);
    end
    chk("stall_ret", retired, 32'd1);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule

// File: doc/multicycle_sequencer.md
# multicycle_sequencer

Control FSM for the multicycle MIPS datapath. It sequences each instruction through fetch, decode, execute, memory and writeback, and generates the per-step enables for the PC, instruction register, register file and memory ports. It sits between the combinational control unit decode outputs and the datapath/memory-controller request lines. It also counts retired instructions and latches halt.

## Interface
Parameters:
- CNT_W, 32, width of retired-instruction counter
- WD_LIMIT, 255, consecutive memory-wait cycles before watchdog trip (only used when SEQ_WATCHDOG_EN defined)

Ports:
- CLK  in  1  system clock, all state updates on rising edge
- RST  in  1  synchronous, active-high reset
- ihit  in  1  instruction memory read complete this cycle
- dhit  in  1  data memory access complete this cycle
- memread  in  1  decoded: load
- memwr  in  1  decoded: store
- regwr  in  1  decoded: writes register file (incl. jal)
- halt  in  1  decoded: halt instruction
- iREN  out  1  instruction memory read request
- dREN  out  1  data memory read request
- dWEN  out  1  data memory write request
- irWEN  out  1  instruction register load
- pcWEN  out  1  PC register load
- regWEN  out  1  register file write enable
- halted  out  1  sticky halt indicator
- timeout  out  1  sticky watchdog trip indicator
- state  out  3  current state encoding (FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, HALT=5)
- retired  out  CNT_W  retired-instruction count

## Operation
- States and outputs:
  - FETCH: iREN=1, irWEN=ihit. On ihit go to DECODE, otherwise stay.
  - DECODE: no enables asserted. Decoded inputs are valid and stable from this state on. If halt, go to HALT and retire. Otherwise go to EXEC.
  - EXEC: pcWEN=1 for exactly one cycle. This covers branch, jump and PC+4 alike; the target is selected by the datapath. If memread|memwr go to MEM; else if regwr go to WB; else go to FETCH and retire.
  - MEM: dWEN=memwr; dREN=memread&~memwr, so a store wins if both are set. On dhit: if memread&~memwr go to WB, else go to FETCH and retire. Without dhit, stay.
  - WB: regWEN=1 for one cycle, then go to FETCH and retire.
  - HALT: halted=1, all enables 0. Terminal state; only RST exits.
- Retire increments retired by 1. The counter wraps modulo 2^CNT_W with no saturation.
- All request and enable outputs are decoded from state plus hit inputs. There are no other registered outputs besides state, retired, halted and timeout.
- ihit is ignored outside FETCH. dhit is ignored outside MEM.

## Timing
- Reset (RST high at an edge): state=FETCH, retired=0, halted=0, timeout=0, watchdog count=0.
  - While in FETCH after reset: iREN=1, irWEN=ihit, all other enables 0.
- RST has priority over every transition, including mid-MEM with a pending dhit. The interrupted instruction is not retired and no write enable is asserted in the reset cycle's successor.
- Minimum latency with a single-cycle hit:
  - Branch or jump without link: 3 cycles.
  - R-type, I-type or jal: 4 cycles.
  - Store: 4 cycles.
  - Load: 5 cycles.
  - Halt: 2 cycles to HALT.
- Each extra wait cycle on ihit or dhit adds exactly one cycle.
- The retired and halted updates are visible the cycle after the retiring transition edge.

## Configuration
- SEQ_WATCHDOG_EN defined:
  - A counter of width clog2(WD_LIMIT+1) increments each cycle spent in FETCH with ihit=0 or in MEM with dhit=0.
  - It clears on any hit, on any state change, and on reset.
  - When the count equals WD_LIMIT and the hit is still low, the next state is HALT with timeout=1 and halted=1. The stalled instruction is not retired.
- SEQ_WATCHDOG_EN undefined: no counter, waits are unbounded, and timeout is tied to 0. The port list is unchanged.

## Test plan
- Reset then R-type (regwr=1) with ihit on the first FETCH cycle:
  - States go 0,1,2,4,0.
  - pcWEN high in cycle 3, regWEN high in cycle 4.
  - retired=1 after cycle 4.
- Load with ihit delayed 2 cycles and dhit delayed 3 cycles:
  - iREN high 3 cycles, dREN high 4 cycles, regWEN pulses once.
  - Total 10 cycles, retired=1.
- memread=1 and memwr=1 together: dWEN=1 and dREN=0 in MEM; after dhit the next state is FETCH (no WB).
- Halt after 3 instructions: state=5, halted=1, retired=4. It stays there 20 cycles with ihit toggling, and all enables stay 0.
- RST asserted in MEM with dhit=1 in the same cycle: next state=FETCH, retired=0, no dWEN/regWEN follow-up.
- With SEQ_WATCHDOG_EN and WD_LIMIT=4, hold ihit=0: HALT is entered after 5 FETCH cycles with timeout=1 and retired unchanged. Without the macro, FETCH is held for 100 cycles and timeout stays 0.
